// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction-refill and load/store paths.
// Data wins by default; a starvation guard and a watchdog bound how long either side can wait.
module mem_port_arbiter #(
    parameter int XLEN       = 32,
    parameter int MAX_STARVE = 3,
    parameter int TIMEOUT    = 64
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_if_req,
    input  logic [XLEN-1:0]   i_if_addr,
    output logic [XLEN-1:0]   o_if_data,
    output logic              o_if_done,
    output logic              o_if_err,
    input  logic              i_dm_req,
    input  logic              i_dm_we,
    input  logic [XLEN-1:0]   i_dm_addr,
    input  logic [XLEN-1:0]   i_dm_wdata,
    input  logic [XLEN/8-1:0] i_dm_wstrb,
    output logic [XLEN-1:0]   o_dm_rdata,
    output logic              o_dm_done,
    output logic              o_dm_err,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [XLEN-1:0]   o_mem_addr,
    output logic [XLEN-1:0]   o_mem_wdata,
    output logic [XLEN/8-1:0] o_mem_wstrb,
    input  logic [XLEN-1:0]   i_mem_rdata,
    input  logic              i_mem_ack,
    output logic              o_busy
);

    localparam int SW = (MAX_STARVE > 0) ? $clog2(MAX_STARVE + 1) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0]   STARVE_LIMIT = SW'(MAX_STARVE);
    localparam logic [WW-1:0]   WD_LAST      = WW'(TIMEOUT - 1);
    localparam logic [XLEN-1:0] WORD_MASK    = ~XLEN'(3);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [SW-1:0] starve_cnt;
    logic [WW-1:0] watchdog;
    logic          pick_i;
    logic          pick_d;
    logic          timeout_hit;

    assign timeout_hit = (watchdog == WD_LAST);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Instruction side only wins a contended cycle once data has been granted MAX_STARVE times in a row.
    always_comb begin
        state_next = state;
        pick_i     = 1'b0;
        pick_d     = 1'b0;
        case (state)
            IDLE: begin
                if (i_if_req && (!i_dm_req || starve_cnt == STARVE_LIMIT)) begin
                    pick_i     = 1'b1;
                    state_next = GRANT_I;
                end else if (i_dm_req) begin
                    pick_d     = 1'b1;
                    state_next = GRANT_D;
                end
            end
            GRANT_I, GRANT_D: begin
                if (i_mem_ack || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            starve_cnt  <= '0;
            watchdog    <= '0;
            o_if_data   <= '0;
            o_if_done   <= 1'b0;
            o_if_err    <= 1'b0;
            o_dm_rdata  <= '0;
            o_dm_done   <= 1'b0;
            o_dm_err    <= 1'b0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_wstrb <= '0;
            o_busy      <= 1'b0;
        end else begin
            o_if_done <= 1'b0;
            o_if_err  <= 1'b0;
            o_dm_done <= 1'b0;
            o_dm_err  <= 1'b0;
            o_busy    <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (pick_i) begin
                        starve_cnt  <= '0;
                        watchdog    <= '0;
                        o_mem_req   <= 1'b1;
                        o_mem_we    <= 1'b0;
                        o_mem_addr  <= i_if_addr & WORD_MASK;
                        o_mem_wdata <= '0;
                        o_mem_wstrb <= '0;
                    end else if (pick_d) begin
                        if (i_if_req && starve_cnt != STARVE_LIMIT) begin
                            starve_cnt <= starve_cnt + SW'(1);
                        end
                        watchdog    <= '0;
                        o_mem_req   <= 1'b1;
                        o_mem_we    <= i_dm_we;
                        o_mem_addr  <= i_dm_addr & WORD_MASK;
                        o_mem_wdata <= i_dm_wdata;
                        o_mem_wstrb <= i_dm_we ? i_dm_wstrb : '0;
                    end
                end
                // An ack in the same cycle as the watchdog expiring still counts as a clean completion.
                GRANT_I, GRANT_D: begin
                    if (i_mem_ack || timeout_hit) begin
                        o_mem_req <= 1'b0;
                        if (state == GRANT_I) begin
                            o_if_done <= 1'b1;
                            o_if_err  <= !i_mem_ack;
                            o_if_data <= i_mem_ack ? i_mem_rdata : '0;
                        end else begin
                            o_dm_done  <= 1'b1;
                            o_dm_err   <= !i_mem_ack;
                            o_dm_rdata <= i_mem_ack ? i_mem_rdata : '0;
                        end
                    end else begin
                        watchdog <= watchdog + WW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
